vend_dispense_sched: RTL and testbench
======================================

Name: vend_dispense_sched

Overview:
- Sits downstream of the vending machine core.
- Accepts vend events from the core: a soda dispense plus a change amount encoded as a 3-bit count of nickels.
- Queues those events in a small FIFO, then runs one job at a time:
  - drives the soda motor until it reports done;
  - then drives the dime and nickel ejector solenoids with timed pulses until the change is paid.
- Keeps the core free of actuator timing and lets back-to-back purchases proceed without loss.

Parameters:
- DEPTH, 4: job FIFO entries; power of 2, at least 2.
- PULSE_LEN, 3: cycles each ejector pulse stays high; at least 1.
- GAP_LEN, 2: low cycles after each ejector pulse; at least 1.
- MOTOR_TIMEOUT, 255: maximum cycles in MOTOR without motor_done_i before the job is forced onward.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-low reset.
- vend_i, in, 1: one-cycle strobe that enqueues a job.
- chan_i, in, 3: change owed for the job, in nickels (0–7 = 0–35c); sampled with vend_i.
- motor_done_i, in, 1: soda motor completion, level-sampled.
- err_clr_i, in, 1: clears err_o.
- motor_o, out, 1: soda motor enable.
- dime_o, out, 1: dime ejector pulse.
- nick_o, out, 1: nickel ejector pulse.
- busy_o, out, 1: state != IDLE or FIFO not empty.
- full_o, out, 1: FIFO count == DEPTH.
- count_o, out, clog2(DEPTH)+1: FIFO occupancy.
- err_o, out, 1: sticky error flag (overflow or motor timeout).

Behaviour:
- Reset (rst sampled 0): FIFO flushed, FSM to IDLE, all counters 0. Every output is 0 one cycle after the reset edge, including mid-job.
- Outputs are decoded from registered state only; there is no combinational input-to-output path.
- FIFO push: vend_i=1 and (not full, or a pop in the same cycle) stores chan_i. count_o updates the next cycle.
- Overflow: vend_i=1, full, and no same-cycle pop → job dropped, err_o set.
- FSM states: IDLE, LOAD, MOTOR, COIN_ON, COIN_GAP.
- IDLE → LOAD when count > 0.
- LOAD:
  - pop the head into a 3-bit rem register;
  - clear the timeout counter;
  - go to MOTOR.
- MOTOR:
  - motor_o = 1.
  - On motor_done_i=1, or when the timeout counter reaches MOTOR_TIMEOUT (which also sets err_o):
    - rem == 0 → IDLE;
    - else → COIN_ON.
- Entering COIN_ON:
  - rem ≥ 2 → dime selected, rem -= 2;
  - rem == 1 → nickel selected, rem -= 1.
  - Coin choice is latched for the pulse.
- COIN_ON: the selected output (dime_o or nick_o) is 1 for exactly PULSE_LEN cycles, then → COIN_GAP.
- COIN_GAP: all outputs 0 for GAP_LEN cycles, then:
  - rem == 0 → IDLE;
  - else → COIN_ON.
- dime_o and nick_o are never high together, and neither is high while motor_o is high.
- Jobs never overlap.
- Latency:
  - vend_i sampled at edge N into an empty FIFO with FSM idle → motor_o high after edge N+2.
  - The first coin pulse starts the cycle after motor_done_i is sampled.
- Coin order per job: all dimes first, then at most one nickel.
- motor_done_i is ignored outside MOTOR.
- err_o:
  - sets on overflow or timeout;
  - clears on err_clr_i;
  - a simultaneous set and clear leaves err_o = 1.
- The FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset: hold rst=0 for 2 cycles with vend_i=1 → count_o=0, every output 0; after release, busy_o=0.
- Single job, chan_i=3, motor_done_i pulsed 4 cycles after motor_o rises → motor_o high 4 cycles, then:
  - dime_o high 3 cycles, low 2;
  - nick_o high 3 cycles, low 2;
  - then IDLE with busy_o=0.
- chan_i=0 → motor_o pulse only; dime_o and nick_o stay 0; IDLE the cycle after motor_done_i.
- chan_i=7 → dime_o pulse 3 times, then nick_o once; each pulse 3 cycles, each followed by a 2-cycle gap.
- Queue:
  - 5 vend_i strobes on consecutive cycles while the FSM is busy with the motor held not-done, DEPTH=4:
    - strobe 1 is popped into LOAD 1 cycle after it is queued, before strobe 3 arrives;
    - strobes 2–5 fill the FIFO to 4 with full_o=1;
    - no strobe is dropped and err_o stays 0.
  - A 6th strobe while full → err_o=1, count_o stays 4.
  - Queued jobs then execute in FIFO order.
- Timeout: hold motor_done_i=0 → motor_o drops after exactly 255 cycles in MOTOR, err_o=1, change still paid. err_clr_i=1 → err_o=0 next cycle.
- Reset mid-pulse: pull rst low during a dime_o pulse → dime_o=0 the next cycle, FIFO empty, no further pulses after release.

Source files
------------

// File: rtl/vend_dispense_sched.sv
// Vend job scheduler: queues {soda, change} events from the vending core and
// sequences the soda motor and the dime/nickel ejectors one job at a time.
module vend_dispense_sched #(
    parameter int DEPTH         = 4,
    parameter int PULSE_LEN     = 3,
    parameter int GAP_LEN       = 2,
    parameter int MOTOR_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vend_i,
    input  logic [2:0]               chan_i,
    input  logic                     motor_done_i,
    input  logic                     err_clr_i,
    output logic                     motor_o,
    output logic                     dime_o,
    output logic                     nick_o,
    output logic                     busy_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (MOTOR_TIMEOUT > PULSE_LEN)
                        ? ((MOTOR_TIMEOUT > GAP_LEN) ? MOTOR_TIMEOUT : GAP_LEN)
                        : ((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, MOTOR, COIN_ON, COIN_GAP} state_t;

    state_t          state, state_n;
    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic [2:0]      rem, rem_n;
    logic            dime_sel, dime_sel_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic            pop, push, ovf, tout, full, err, coin_start;

    assign full = (count == CW'(DEPTH));
    assign push = vend_i && (!full || pop);
    assign ovf  = vend_i && full && !pop;

    // One shared timer measures motor time, pulse width and gap width;
    // it restarts from zero on every state change.
    always_comb begin
        state_n    = state;
        rem_n      = rem;
        dime_sel_n = dime_sel;
        tmr_n      = tmr + TW'(1);
        pop        = 1'b0;
        tout       = 1'b0;
        coin_start = 1'b0;
        case (state)
            IDLE: begin
                tmr_n = '0;
                if (count != '0) state_n = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                rem_n   = mem[rptr];
                tmr_n   = '0;
                state_n = MOTOR;
            end
            MOTOR: begin
                if (motor_done_i || tmr == TW'(MOTOR_TIMEOUT - 1)) begin
                    tout  = !motor_done_i;
                    tmr_n = '0;
                    if (rem == 3'd0) state_n = IDLE;
                    else             coin_start = 1'b1;
                end
            end
            COIN_ON: begin
                if (tmr == TW'(PULSE_LEN - 1)) begin
                    tmr_n   = '0;
                    state_n = COIN_GAP;
                end
            end
            COIN_GAP: begin
                if (tmr == TW'(GAP_LEN - 1)) begin
                    tmr_n = '0;
                    if (rem == 3'd0) state_n = IDLE;
                    else             coin_start = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Dimes first; a lone nickel only when one nickel remains.
        if (coin_start) begin
            state_n    = COIN_ON;
            dime_sel_n = (rem >= 3'd2);
            rem_n      = rem - ((rem >= 3'd2) ? 3'd2 : 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rem      <= '0;
            dime_sel <= 1'b0;
            tmr      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            dime_sel <= dime_sel_n;
            tmr      <= tmr_n;
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf || tout)    err <= 1'b1;
            else if (err_clr_i) err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= chan_i;
    end

    assign motor_o = (state == MOTOR);
    assign dime_o  = (state == COIN_ON) && dime_sel;
    assign nick_o  = (state == COIN_ON) && !dime_sel;
    assign busy_o  = (state != IDLE) || (count != '0);
    assign full_o  = full;
    assign count_o = count;
    assign err_o   = err;
endmodule

// File: tb/tb_vend_dispense_sched.sv
// Bench for vend_dispense_sched: a job-queue / coin-script model checked every
// cycle, plus directed scenarios with hand-computed timing.
module tb_vend_dispense_sched;
    localparam int DEPTH = 4, PL = 3, GL = 2, TO = 255;

    logic       clk = 1'b0, rst = 1'b0, vend_i = 1'b0, motor_done_i = 1'b0, err_clr_i = 1'b0;
    logic [2:0] chan_i = '0;
    logic       motor_o, dime_o, nick_o, busy_o, full_o, err_o;
    logic [2:0] count_o;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    vend_dispense_sched #(.DEPTH(DEPTH), .PULSE_LEN(PL), .GAP_LEN(GL), .MOTOR_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .vend_i(vend_i), .chan_i(chan_i),
        .motor_done_i(motor_done_i), .err_clr_i(err_clr_i),
        .motor_o(motor_o), .dime_o(dime_o), .nick_o(nick_o), .busy_o(busy_o),
        .full_o(full_o), .count_o(count_o), .err_o(err_o));

    always #5 clk = ~clk;

    // Model: pending jobs, current phase (0 idle, 1 load, 2 motor, 3 coins),
    // and a per-cycle coin script (1 dime, 2 nickel, 0 quiet) for the job.
    int q[$];
    int scr[$];
    int ph = 0, mcyc = 0, job = 0;
    bit merr = 0;

    always @(posedge clk) begin
        int  sz;
        bit  pop, ovf, tout;
        sz = q.size(); pop = (ph == 1); ovf = 0; tout = 0;
        if (!rst) begin
            q.delete(); scr.delete(); ph = 0; mcyc = 0; merr = 0;
        end else begin
            case (ph)
                0: if (sz > 0) ph = 1;
                1: begin job = q.pop_front(); ph = 2; mcyc = 0; end
                2: begin
                    mcyc++;
                    if (motor_done_i || mcyc == TO) begin
                        tout = !motor_done_i;
                        for (int i = 0; i < job / 2; i++) begin
                            repeat (PL) scr.push_back(1);
                            repeat (GL) scr.push_back(0);
                        end
                        if (job % 2 == 1) begin
                            repeat (PL) scr.push_back(2);
                            repeat (GL) scr.push_back(0);
                        end
                        ph = (scr.size() > 0) ? 3 : 0;
                    end
                end
                default: begin
                    void'(scr.pop_front());
                    if (scr.size() == 0) ph = 0;
                end
            endcase
            if (vend_i) begin
                if (sz < DEPTH || pop) q.push_back(int'(chan_i));
                else ovf = 1;
            end
            if (ovf || tout) merr = 1;
            else if (err_clr_i) merr = 0;
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = {ph == 2, ph == 3 && scr[0] == 1, ph == 3 && scr[0] == 2,
                     ph != 0 || q.size() > 0, q.size() == DEPTH, 3'(q.size()), merr};
            act_v = {motor_o, dime_o, nick_o, busy_o, full_o, count_o, err_o};
            n_chk++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got m/d/n/b/f/cnt/e=%b required %b", $time, act_v, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    // Enqueue one job and run until idle; done pulses after dly motor cycles (0 = never).
    task automatic run_job(input int ch, input int dly, output int nm, output int nd, output int nn,
                           output int pd, output int pn, output int mfirst, output int idle_c);
        bit pdm, pnm;
        nm = 0; nd = 0; nn = 0; pd = 0; pn = 0; mfirst = -1; idle_c = -1; pdm = 0; pnm = 0;
        vend_i = 1; chan_i = 3'(ch); tick(); vend_i = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (motor_o) begin nm++; if (mfirst < 0) mfirst = c; end
            motor_done_i = (dly > 0 && motor_o && nm == dly);
            if (dime_o) nd++;
            if (nick_o) nn++;
            if (dime_o && !pdm) pd++;
            if (nick_o && !pnm) pn++;
            pdm = dime_o; pnm = nick_o;
            if (!busy_o) begin idle_c = c; break; end
        end
        motor_done_i = 0;
        if (idle_c < 0) chk("job_timeout", 1, 0);
    endtask

    initial begin
        int nm, nd, nn, pd, pn, mf, ic, hits;
        // Reset with vend held high
        rst = 0; vend_i = 1; chan_i = 3'd5;
        tick(); chk_en = 1; tick();
        chk("rst_count", int'(count_o), 0);
        chk("rst_outs", int'({motor_o, dime_o, nick_o, busy_o, full_o, err_o}), 0);
        rst = 1; vend_i = 0; tick();
        chk("rst_busy", int'(busy_o), 0);

        run_job(3, 4, nm, nd, nn, pd, pn, mf, ic);
        chk("j3_latency", mf, 1); chk("j3_motor", nm, 4);
        chk("j3_dime", nd, 3); chk("j3_nick", nn, 3);
        chk("j3_pulses", pd * 10 + pn, 11); chk("j3_idle", ic, 15);

        run_job(0, 4, nm, nd, nn, pd, pn, mf, ic);
        chk("j0_motor", nm, 4); chk("j0_coins", nd + nn, 0); chk("j0_idle", ic, 5);

        run_job(7, 4, nm, nd, nn, pd, pn, mf, ic);
        chk("j7_dime", nd, 9); chk("j7_nick", nn, 3);
        chk("j7_pulses", pd * 10 + pn, 31); chk("j7_idle", ic, 25);

        run_job(1, 0, nm, nd, nn, pd, pn, mf, ic);
        chk("to_motor", nm, TO); chk("to_err", int'(err_o), 1);
        chk("to_nick", nn, 3); chk("to_idle", ic, TO + 6);
        err_clr_i = 1; tick(); err_clr_i = 0;
        chk("err_clr", int'(err_o), 0);

        // Queue: five back-to-back strobes, motor held not-done, then overflow
        motor_done_i = 0;
        for (int i = 0; i < 5; i++) begin
            vend_i = 1; chan_i = 3'((i * 3 + 3) % 8); tick();
        end
        vend_i = 0;
        chk("q_count", int'(count_o), 4); chk("q_full", int'(full_o), 1);
        chk("q_err", int'(err_o), 0);
        vend_i = 1; chan_i = 3'd7; tick(); vend_i = 0;
        chk("ovf_err", int'(err_o), 1); chk("ovf_count", int'(count_o), 4);
        motor_done_i = 1;
        for (int c = 0; c < 2000 && busy_o; c++) tick();
        chk("q_drain", int'(busy_o), 0);
        motor_done_i = 0; err_clr_i = 1; tick(); err_clr_i = 0;

        // Reset during a dime pulse
        vend_i = 1; chan_i = 3'd4; tick(); vend_i = 0; motor_done_i = 1;
        for (int c = 0; c < 50 && !dime_o; c++) tick();
        chk("mid_dime_seen", int'(dime_o), 1);
        rst = 0; tick(); rst = 1; motor_done_i = 0;
        chk("mid_rst_dime", int'(dime_o), 0);
        chk("mid_rst_count", int'(count_o), 0);
        hits = 0;
        for (int c = 0; c < 20; c++) begin tick(); hits += int'(dime_o) + int'(nick_o) + int'(motor_o); end
        chk("mid_rst_quiet", hits, 0);

        // Randomized traffic, including occasional resets and long motor runs
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(0, 599) != 0);
            vend_i       = ($urandom_range(0, 3) == 0);
            chan_i       = 3'($urandom_range(0, 7));
            motor_done_i = (c < 2500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
            err_clr_i    = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 1; vend_i = 0; err_clr_i = 0; motor_done_i = 1;
        for (int c = 0; c < 3000 && busy_o; c++) tick();
        chk("final_idle", int'(busy_o), 0);
        motor_done_i = 0; tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
